order_risk_gate: RTL and testbench
==================================

Name: order_risk_gate

Overview:
- Pre-trade risk gate directly downstream of the trading engine's decision stage.
- Consumes the single-cycle candidate_order/candidate_valid pulses and applies kill switch, message-type, price-cap, duplicate and order-rate checks.
- Queues accepted orders in a small FIFO that drives the order transmitter over a valid/ready handshake.
- Upstream cannot be stalled, so every candidate is either accepted or rejected with a reason code in the cycle it arrives.

Parameters:
- FIFO_DEPTH, 8: output queue entries; power of two, at least 2.
- TOKEN_MAX, 4: rate-limiter bucket size, and the token count at reset.
- REFILL_PERIOD, 16: cycles per token refill; at least 2.
- DEDUP_WINDOW, 8: cycles during which a repeat of the last accepted instrument_id is rejected.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- kill_switch  in  1  level; rejects all candidates and flushes the queue.
- price_cap  in  32  unsigned maximum acceptable price.
- candidate_order  in  64  order word: {msg_type[63:56], instrument_id[55:32], price[31:0]}.
- candidate_valid  in  1  single-cycle qualifier; no backpressure.
- order_out  out  64  head-of-queue order.
- order_valid  out  1  queue non-empty.
- order_ready  in  1  transmitter accepts order_out this cycle.
- reject_valid  out  1  registered pulse, one cycle after a rejected candidate.
- reject_code  out  3  reason for the last reject; holds its value between rejects.
- accept_count  out  32  accepted orders since reset; wraps.
- reject_count  out  32  rejected orders since reset; wraps.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset values:
  - all outputs 0; queue empty.
  - tokens = TOKEN_MAX; refill counter = 0.
  - dedup window expired; last_id = 0.
- Checks are evaluated combinationally on the candidate in cycle N. The first failing check sets reject_code, in this priority order:
  - 1 kill_switch high
  - 2 msg_type != 8'h01
  - 3 price == 0 or price > price_cap (unsigned)
  - 4 dedup: instrument_id == last_id and dedup counter < DEDUP_WINDOW
  - 5 tokens == 0
  - 6 queue full
- Accept:
  - queue written at the edge ending cycle N, so order_valid/order_out are visible from cycle N+1 (1-cycle latency).
  - tokens decremented; last_id loaded; dedup counter cleared to 0; accept_count incremented.
- Reject:
  - reject_valid = 1 and reject_code set in cycle N+1; reject_count incremented; no other state changes.
- Dedup counter:
  - increments each cycle and saturates at DEDUP_WINDOW.
  - only the most recent accepted id is tracked.
- Refill counter:
  - counts 0..REFILL_PERIOD-1 and wraps.
  - on wrap, tokens = min(tokens+1, TOKEN_MAX).
  - the token check uses the pre-refill value; refill and consume in the same cycle net to zero change.
- Queue:
  - show-ahead FIFO; a pop occurs when order_valid && order_ready.
  - simultaneous push and pop is allowed when full; the full check in reason 6 uses the pre-pop level, so such a candidate is rejected.
  - pop when empty is ignored.
  - order_out holds stable while order_valid && !order_ready.
- kill_switch:
  - while high, the queue is flushed synchronously each cycle, giving order_valid = 0 the next cycle.
  - counters and tokens keep running.
- Async reset asserted mid-operation clears the queue immediately, including any in-flight handshake.

Decomposition:
- Shared package holds:
  - the order field slice constants (MSG_TYPE_HI/LO, INSTR_HI/LO, PRICE_HI/LO)
  - MSG_NEW_ORDER = 8'h01
  - reject code constants: REJ_NONE=0, REJ_KILL=1, REJ_TYPE=2, REJ_PRICE=3, REJ_DUP=4, REJ_RATE=5, REJ_FULL=6
- One natural sub-module: order_fifo, a parameterised show-ahead synchronous FIFO with flush and level output.
- The token bucket and dedup logic stay inline in the top module.

Test Plan:
- Reset, then candidate {01,000123,00000064} with price_cap=0x100 → order_valid=1 next cycle, order_out=0x0100012300000064, accept_count=1.
- Same instrument 3 cycles later → reject_valid with code 4; the same id after 8 idle cycles → accepted.
- 5 distinct valid orders on consecutive cycles, order_ready=0 → first 4 accepted, 5th rejected code 5. After 16 cycles, one more is accepted.
- order_ready=0 and 8 accepted orders with the refill period satisfied → fifo_level=8; 9th rejected code 6. Raise order_ready → orders drain in order, one per cycle.
- msg_type 02 → code 2; price 0 or price_cap+1 → code 3; kill_switch=1 with order 01 and price 0 → code 1, queue flushed, order_valid=0 next cycle.
- Async reset asserted mid-drain → all outputs 0 immediately; tokens=4 after release.

Source files
------------

// File: rtl/order_risk_gate_pkg.sv
// order_risk_gate_pkg: order word layout, message type and reject reason codes
package order_risk_gate_pkg;
    localparam int MSG_TYPE_HI = 63;
    localparam int MSG_TYPE_LO = 56;
    localparam int INSTR_HI    = 55;
    localparam int INSTR_LO    = 32;
    localparam int PRICE_HI    = 31;
    localparam int PRICE_LO    = 0;

    localparam logic [7:0] MSG_NEW_ORDER = 8'h01;

    localparam logic [2:0] REJ_NONE  = 3'd0;
    localparam logic [2:0] REJ_KILL  = 3'd1;
    localparam logic [2:0] REJ_TYPE  = 3'd2;
    localparam logic [2:0] REJ_PRICE = 3'd3;
    localparam logic [2:0] REJ_DUP   = 3'd4;
    localparam logic [2:0] REJ_RATE  = 3'd5;
    localparam logic [2:0] REJ_FULL  = 3'd6;
endpackage

// File: rtl/order_risk_gate_fifo.sv
// order_fifo: show-ahead synchronous FIFO with synchronous flush and occupancy output
module order_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push, do_pop;

    // Pops on an empty queue are dropped; a push into a full queue only lands when a pop frees the slot.
    always_comb begin
        do_pop  = pop_i && (level_q != '0);
        do_push = push_i && ((level_q != LW'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            level_q  <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset; the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = level_q != '0;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign full_o  = level_q == LW'(DEPTH);
    assign level_o = level_q;
endmodule

// File: rtl/order_risk_gate.sv
// order_risk_gate: pre-trade checks (kill, type, price, dedup, rate, full) feeding an output order queue
module order_risk_gate
    import order_risk_gate_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int TOKEN_MAX     = 4,
    parameter int REFILL_PERIOD = 16,
    parameter int DEDUP_WINDOW  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          kill_switch,
    input  logic [31:0]                   price_cap,
    input  logic [63:0]                   candidate_order,
    input  logic                          candidate_valid,
    output logic [63:0]                   order_out,
    output logic                          order_valid,
    input  logic                          order_ready,
    output logic                          reject_valid,
    output logic [2:0]                    reject_code,
    output logic [31:0]                   accept_count,
    output logic [31:0]                   reject_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int TW = $clog2(TOKEN_MAX + 1);
    localparam int RW = $clog2(REFILL_PERIOD);
    localparam int DW = $clog2(DEDUP_WINDOW + 1);

    logic [TW-1:0] tokens_q, tokens_d, tokens_inc;
    logic [RW-1:0] refill_q, refill_d;
    logic [DW-1:0] dedup_q, dedup_d;
    logic [23:0]   last_id_q, last_id_d;
    logic          rej_valid_q, rej_valid_d;
    logic [2:0]    rej_code_q, rej_code_d;
    logic [31:0]   acc_cnt_q, acc_cnt_d, rej_cnt_q, rej_cnt_d;
    logic [7:0]    msg;
    logic [23:0]   id;
    logic [31:0]   price;
    logic [2:0]    code;
    logic          accept, reject, refill_wrap, fifo_full;

    // Reason priority: the first failing check wins; full uses the pre-pop occupancy.
    always_comb begin
        msg   = candidate_order[MSG_TYPE_HI:MSG_TYPE_LO];
        id    = candidate_order[INSTR_HI:INSTR_LO];
        price = candidate_order[PRICE_HI:PRICE_LO];
        code  = kill_switch                                        ? REJ_KILL  :
                (msg != MSG_NEW_ORDER)                             ? REJ_TYPE  :
                (price == '0 || price > price_cap)                 ? REJ_PRICE :
                (id == last_id_q && dedup_q < DW'(DEDUP_WINDOW))   ? REJ_DUP   :
                (tokens_q == '0)                                   ? REJ_RATE  :
                fifo_full                                          ? REJ_FULL  : REJ_NONE;
        accept = candidate_valid && (code == REJ_NONE);
        reject = candidate_valid && (code != REJ_NONE);
    end

    // Next state: refill and consume in one cycle cancel out; dedup age saturates at the window.
    always_comb begin
        refill_wrap = refill_q == RW'(REFILL_PERIOD - 1);
        refill_d    = refill_wrap ? '0 : refill_q + 1'b1;
        tokens_inc  = (tokens_q < TW'(TOKEN_MAX)) ? tokens_q + 1'b1 : tokens_q;
        tokens_d    = refill_wrap ? (accept ? tokens_q : tokens_inc) : (accept ? tokens_q - 1'b1 : tokens_q);
        dedup_d     = accept ? '0 : (dedup_q < DW'(DEDUP_WINDOW)) ? dedup_q + 1'b1 : dedup_q;
        last_id_d   = accept ? id : last_id_q;
        rej_valid_d = reject;
        rej_code_d  = reject ? code : rej_code_q;
        acc_cnt_d   = acc_cnt_q + 32'(accept);
        rej_cnt_d   = rej_cnt_q + 32'(reject);
    end

    // Gate state registers; the dedup window starts expired and the bucket starts full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tokens_q    <= TW'(TOKEN_MAX);
            refill_q    <= '0;
            dedup_q     <= DW'(DEDUP_WINDOW);
            last_id_q   <= '0;
            rej_valid_q <= 1'b0;
            rej_code_q  <= REJ_NONE;
            acc_cnt_q   <= '0;
            rej_cnt_q   <= '0;
        end else begin
            tokens_q    <= tokens_d;
            refill_q    <= refill_d;
            dedup_q     <= dedup_d;
            last_id_q   <= last_id_d;
            rej_valid_q <= rej_valid_d;
            rej_code_q  <= rej_code_d;
            acc_cnt_q   <= acc_cnt_d;
            rej_cnt_q   <= rej_cnt_d;
        end
    end

    order_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (kill_switch),
        .push_i  (accept),
        .data_i  (candidate_order),
        .pop_i   (order_ready),
        .data_o  (order_out),
        .valid_o (order_valid),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign reject_valid = rej_valid_q;
    assign reject_code  = rej_code_q;
    assign accept_count = acc_cnt_q;
    assign reject_count = rej_cnt_q;
endmodule

// File: tb/tb_order_risk_gate.sv
// tb_order_risk_gate: directed scenario tests for order_risk_gate
module tb_order_risk_gate;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        kill_switch = 1'b0;
    logic [31:0] price_cap = 32'h100;
    logic [63:0] candidate_order = '0;
    logic        candidate_valid = 1'b0;
    logic [63:0] order_out;
    logic        order_valid;
    logic        order_ready = 1'b0;
    logic        reject_valid;
    logic [2:0]  reject_code;
    logic [31:0] accept_count, reject_count;
    logic [3:0]  fifo_level;
    int checks = 0;
    int errors = 0;

    order_risk_gate dut (
        .clk             (clk),
        .reset           (reset),
        .kill_switch     (kill_switch),
        .price_cap       (price_cap),
        .candidate_order (candidate_order),
        .candidate_valid (candidate_valid),
        .order_out       (order_out),
        .order_valid     (order_valid),
        .order_ready     (order_ready),
        .reject_valid    (reject_valid),
        .reject_code     (reject_code),
        .accept_count    (accept_count),
        .reject_count    (reject_count),
        .fifo_level      (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [7:0] m, input logic [23:0] i, input logic [31:0] p);
        return {m, i, p};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic send(input logic [63:0] o);
        candidate_order = o;
        candidate_valid = 1'b1;
        cyc();
        candidate_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        kill_switch = 1'b0;
        candidate_valid = 1'b0;
        order_ready = 1'b0;
        price_cap = 32'h100;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({order_out, order_valid, reject_valid, reject_code, accept_count, reject_count, fifo_level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got out=%h v=%b rv=%b rc=%0d ac=%0d rj=%0d lvl=%0d want all 0",
                     order_out, order_valid, reject_valid, reject_code, accept_count, reject_count, fifo_level);
        end
    endtask

    task automatic test_accept_dedup();
        do_reset();
        send(mk(8'h01, 24'h000123, 32'h64));
        checks++;
        if (order_valid !== 1'b1 || order_out !== 64'h0100012300000064) begin
            errors++; $display("FAIL accept_out got v=%b out=%h want 1 0100012300000064", order_valid, order_out);
        end
        checks++;
        if (accept_count !== 32'd1 || fifo_level !== 4'd1 || reject_valid !== 1'b0) begin
            errors++; $display("FAIL accept_count got ac=%0d lvl=%0d rv=%b want 1 1 0", accept_count, fifo_level, reject_valid);
        end
        idle(2);
        send(mk(8'h01, 24'h000123, 32'h64));
        checks++;
        if (reject_valid !== 1'b1 || reject_code !== 3'd4 || reject_count !== 32'd1) begin
            errors++; $display("FAIL dedup_reject got rv=%b rc=%0d rj=%0d want 1 4 1", reject_valid, reject_code, reject_count);
        end
        cyc();
        checks++;
        if (reject_valid !== 1'b0 || reject_code !== 3'd4) begin
            errors++; $display("FAIL reject_hold got rv=%b rc=%0d want 0 4", reject_valid, reject_code);
        end
        idle(7);
        send(mk(8'h01, 24'h000123, 32'h64));
        checks++;
        if (accept_count !== 32'd2 || reject_valid !== 1'b0 || fifo_level !== 4'd2) begin
            errors++; $display("FAIL dedup_expire got ac=%0d rv=%b lvl=%0d want 2 0 2", accept_count, reject_valid, fifo_level);
        end
    endtask

    task automatic test_rate_limit();
        do_reset();
        for (int i = 0; i < 5; i++) send(mk(8'h01, 24'h200 + 24'(i), 32'h10));
        checks++;
        if (accept_count !== 32'd4 || reject_count !== 32'd1 || reject_valid !== 1'b1 || reject_code !== 3'd5) begin
            errors++; $display("FAIL rate_reject got ac=%0d rj=%0d rv=%b rc=%0d want 4 1 1 5", accept_count, reject_count, reject_valid, reject_code);
        end
        idle(16);
        send(mk(8'h01, 24'h300, 32'h10));
        checks++;
        if (accept_count !== 32'd5 || fifo_level !== 4'd5) begin
            errors++; $display("FAIL rate_refill got ac=%0d lvl=%0d want 5 5", accept_count, fifo_level);
        end
    endtask

    task automatic test_full_drain();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(mk(8'h01, 24'h400 + 24'(i), 32'h20 + 32'(i)));
            idle(15);
        end
        checks++;
        if (fifo_level !== 4'd8 || order_out !== mk(8'h01, 24'h400, 32'h20)) begin
            errors++; $display("FAIL full_level got lvl=%0d head=%h want 8 head order 0", fifo_level, order_out);
        end
        send(mk(8'h01, 24'h500, 32'h30));
        checks++;
        if (reject_valid !== 1'b1 || reject_code !== 3'd6 || fifo_level !== 4'd8) begin
            errors++; $display("FAIL full_reject got rv=%b rc=%0d lvl=%0d want 1 6 8", reject_valid, reject_code, fifo_level);
        end
        cyc();
        checks++;
        if (order_out !== mk(8'h01, 24'h400, 32'h20)) begin
            errors++; $display("FAIL head_stable got %h want order 0", order_out);
        end
        order_ready = 1'b1;
        send(mk(8'h01, 24'h501, 32'h31));
        checks++;
        if (reject_code !== 3'd6 || reject_valid !== 1'b1 || fifo_level !== 4'd7 || order_out !== mk(8'h01, 24'h401, 32'h21)) begin
            errors++; $display("FAIL full_pushpop got rv=%b rc=%0d lvl=%0d head=%h want 1 6 7 order 1", reject_valid, reject_code, fifo_level, order_out);
        end
        for (int i = 2; i < 8; i++) begin
            cyc();
            checks++;
            if (order_out !== mk(8'h01, 24'h400 + 24'(i), 32'h20 + 32'(i)) || fifo_level !== 4'(8 - i)) begin
                errors++; $display("FAIL drain_%0d got head=%h lvl=%0d want order %0d lvl %0d", i, order_out, fifo_level, i, 8 - i);
            end
        end
        idle(2);
        checks++;
        if (order_valid !== 1'b0 || fifo_level !== 4'd0 || order_out !== 64'd0) begin
            errors++; $display("FAIL drain_empty got v=%b lvl=%0d out=%h want 0 0 0", order_valid, fifo_level, order_out);
        end
    endtask

    task automatic test_checks_kill();
        do_reset();
        send(mk(8'h02, 24'h600, 32'h10));
        checks++;
        if (reject_valid !== 1'b1 || reject_code !== 3'd2) begin
            errors++; $display("FAIL type_reject got rv=%b rc=%0d want 1 2", reject_valid, reject_code);
        end
        send(mk(8'h01, 24'h601, 32'h0));
        checks++;
        if (reject_valid !== 1'b1 || reject_code !== 3'd3) begin
            errors++; $display("FAIL price_zero got rv=%b rc=%0d want 1 3", reject_valid, reject_code);
        end
        send(mk(8'h02, 24'h602, 32'h0));
        checks++;
        if (reject_code !== 3'd2) begin
            errors++; $display("FAIL type_over_price got rc=%0d want 2", reject_code);
        end
        send(mk(8'h01, 24'h603, 32'h101));
        checks++;
        if (reject_valid !== 1'b1 || reject_code !== 3'd3) begin
            errors++; $display("FAIL price_over got rv=%b rc=%0d want 1 3", reject_valid, reject_code);
        end
        send(mk(8'h01, 24'h604, 32'h100));
        checks++;
        if (reject_valid !== 1'b0 || accept_count !== 32'd1 || order_valid !== 1'b1) begin
            errors++; $display("FAIL price_at_cap got rv=%b ac=%0d v=%b want 0 1 1", reject_valid, accept_count, order_valid);
        end
        kill_switch = 1'b1;
        send(mk(8'h01, 24'h605, 32'h0));
        checks++;
        if (reject_valid !== 1'b1 || reject_code !== 3'd1 || order_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL kill got rv=%b rc=%0d v=%b lvl=%0d want 1 1 0 0", reject_valid, reject_code, order_valid, fifo_level);
        end
        checks++;
        if (reject_count !== 32'd5 || accept_count !== 32'd1) begin
            errors++; $display("FAIL kill_counts got rj=%0d ac=%0d want 5 1", reject_count, accept_count);
        end
        kill_switch = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) send(mk(8'h01, 24'h700 + 24'(i), 32'h40));
        order_ready = 1'b1;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({order_out, order_valid, reject_valid, reject_code, accept_count, reject_count, fifo_level} !== '0) begin
            errors++; $display("FAIL async_reset got out=%h v=%b ac=%0d lvl=%0d want all 0", order_out, order_valid, accept_count, fifo_level);
        end
        do_reset();
        for (int i = 0; i < 5; i++) send(mk(8'h01, 24'h800 + 24'(i), 32'h40));
        checks++;
        if (accept_count !== 32'd4 || reject_code !== 3'd5 || fifo_level !== 4'd4) begin
            errors++; $display("FAIL tokens_after_reset got ac=%0d rc=%0d lvl=%0d want 4 5 4", accept_count, reject_code, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_accept_dedup();
        test_rate_limit();
        test_full_drain();
        test_checks_kill();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
